// File: rtl/mdu.sv
// rtl/mdu.sv - multi-cycle multiply/divide unit producing the HI/LO registers
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic [1:0]    op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d, done_q, done_d;

  logic [63:0] prod_s, prod_u;
  logic [31:0] dvsr, abs_a, abs_b, squ, sru, sq, sr, uq, ur;
  logic        neg_a, neg_b, div_zero;

  // Results computed from the latched operands; only committed on the final edge
  always_comb begin
    prod_s   = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u   = {32'd0, a_q} * {32'd0, b_q};
    div_zero = (b_q == 32'd0);
    // Substitute divisor keeps the dividers well-defined; the result is discarded on /0
    dvsr     = div_zero ? 32'd1 : b_q;
    neg_a    = a_q[31];
    neg_b    = b_q[31];
    abs_a    = neg_a ? (~a_q + 32'd1) : a_q;
    abs_b    = neg_b ? (~dvsr + 32'd1) : dvsr;
    // Magnitude division avoids the signed overflow corner (0x80000000 / -1)
    squ      = abs_a / abs_b;
    sru      = abs_a % abs_b;
    sq       = (neg_a ^ neg_b) ? (~squ + 32'd1) : squ;
    sr       = neg_a ? (~sru + 32'd1) : sru;
    uq       = a_q / dvsr;
    ur       = a_q % dvsr;
  end

  // Next-state: accept when idle, count down while busy, commit on 1 -> 0
  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    a_d    = a_q;
    b_d    = b_q;
    op_d   = op_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (busy_q) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        case (op_q)
          2'b00: {hi_d, lo_d} = prod_s;
          2'b01: {hi_d, lo_d} = prod_u;
          2'b10: if (!div_zero) begin lo_d = sq; hi_d = sr; end
          default: if (!div_zero) begin lo_d = uq; hi_d = ur; end
        endcase
      end
    end else if (start) begin
      case (op)
        OP_MULT, OP_MULTU: begin
          a_d = a; b_d = b; op_d = op[1:0];
          cnt_d = CW'(MULT_CYCLES); busy_d = 1'b1;
        end
        OP_DIV, OP_DIVU: begin
          a_d = a; b_d = b; op_d = op[1:0];
          cnt_d = CW'(DIV_CYCLES); busy_d = 1'b1;
        end
        OP_MTHI: hi_d = a;
        OP_MTLO: lo_d = a;
        default: ;
      endcase
    end
  end

  // State registers; reset aborts any running operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      a_q    <= a_d;
      b_q    <= b_d;
      op_q   <= op_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
